// File: rtl/bist_tpg_misr_if.sv
// rtl/bist_tpg_misr_if.sv - controller/CUT side signal bundle for the BIST pattern/signature stage
interface bist_tpg_misr_if #(
  parameter int W = 8
);
  logic         RUNNING;
  logic         EN;
  logic         BIST_END;
  logic [W-1:0] CUT_RESP;
  logic [W-1:0] PATTERN;
  logic [W-1:0] SIGNATURE;
  logic [7:0]   PAT_CNT;
  logic         DONE;
  logic         PASS;

  // Controller / CUT side: drives session flags and the CUT response.
  modport master (
    output RUNNING, EN, BIST_END, CUT_RESP,
    input  PATTERN, SIGNATURE, PAT_CNT, DONE, PASS
  );

  // Pattern generator / signature compactor side.
  modport slave (
    input  RUNNING, EN, BIST_END, CUT_RESP,
    output PATTERN, SIGNATURE, PAT_CNT, DONE, PASS
  );
endinterface

// File: rtl/bist_tpg_misr.sv
// rtl/bist_tpg_misr.sv - LFSR test pattern generator and MISR response compactor with golden compare
module bist_tpg_misr #(
  parameter int           W      = 8,
  parameter logic [W-1:0] TAPS   = 8'hB8,
  parameter logic [W-1:0] SEED   = 8'h01,
  parameter logic [W-1:0] GOLDEN = 8'h00
) (
  input logic            CLK,
  input logic            RESET,
  bist_tpg_misr_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic         do_step;
  logic         do_reload;
  logic         do_check;

  logic [W-1:0] pattern_q;
  logic [W-1:0] signature_q;
  logic [7:0]   pat_cnt_q;
  logic         done_q;
  logic         pass_q;

  // LFSR and MISR share one feedback polynomial.
  function automatic logic fb(input logic [W-1:0] x);
    return ^(x & TAPS);
  endfunction

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath controls; abort/end-of-session reload wins over a step.
  always_comb begin
    state_d   = state_q;
    do_step   = 1'b0;
    do_reload = 1'b0;
    do_check  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        do_step = bus.EN;
        if (bus.RUNNING) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.BIST_END) begin
          do_step = bus.EN;
          state_d = ST_CHECK;
        end else if (!bus.RUNNING) begin
          do_reload = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          do_step = bus.EN;
        end
      end
      ST_CHECK: begin
        do_check = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (!bus.BIST_END) begin
          do_reload = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        do_reload = 1'b1;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Pattern/signature/count registers and the end-of-test verdict.
  always_ff @(posedge CLK) begin
    if (RESET || do_reload) begin
      pattern_q   <= SEED;
      signature_q <= '0;
      pat_cnt_q   <= 8'd0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else if (do_step) begin
      pattern_q   <= {pattern_q[W-2:0], fb(pattern_q)};
      signature_q <= {signature_q[W-2:0], fb(signature_q)} ^ bus.CUT_RESP;
      if (pat_cnt_q != 8'hFF) begin
        pat_cnt_q <= pat_cnt_q + 8'd1;
      end
    end else if (do_check) begin
      done_q <= 1'b1;
      pass_q <= (signature_q == GOLDEN);
    end
  end

  assign bus.PATTERN   = pattern_q;
  assign bus.SIGNATURE = signature_q;
  assign bus.PAT_CNT   = pat_cnt_q;
  assign bus.DONE      = done_q;
  assign bus.PASS      = pass_q;

endmodule

// File: tb/tb_bist_tpg_misr.sv
// tb/tb_bist_tpg_misr.sv - directed self-checking bench for bist_tpg_misr
module tb_bist_tpg_misr;
  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  bist_tpg_misr_if #(.W(8)) bus ();

  bist_tpg_misr #(
    .W(8), .TAPS(8'hB8), .SEED(8'h01), .GOLDEN(8'h00)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_seq [5];
  logic [7:0] mpat;
  logic [7:0] msig;
  logic [7:0] sig1;
  logic       seen_zero;

  function automatic logic bfb(input logic [7:0] x);
    return ^(x & 8'hB8);
  endfunction

  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {x[6:0], bfb(x)};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 81 EN cycles, 0x01 injected on pattern 40, BIST_END coincident with the last EN.
  task automatic inject_session(output logic [7:0] sig_out);
    logic [7:0] ms;
    ms = 8'h00;
    for (int i = 0; i < 81; i++) begin
      bus.RUNNING  = 1'b1;
      bus.EN       = 1'b1;
      bus.CUT_RESP = (i == 39) ? 8'h01 : 8'h00;
      bus.BIST_END = (i == 80);
      ms = nxt(ms) ^ bus.CUT_RESP;
      tick();
    end
    check("inj_done_in_check", bus.DONE, 1'b0);
    bus.EN       = 1'b0;
    bus.RUNNING  = 1'b0;
    bus.CUT_RESP = 8'h00;
    tick();
    check("inj_done", bus.DONE, 1'b1);
    check("inj_pass", bus.PASS, 1'b0);
    check("inj_cnt", bus.PAT_CNT, 8'd81);
    check("inj_sig_model", bus.SIGNATURE, ms);
    check("inj_sig_nonzero", (bus.SIGNATURE != 8'h00), 1'b1);
    sig_out = bus.SIGNATURE;
  endtask

  initial begin
    exp_seq = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    RESET        = 1'b1;
    bus.RUNNING  = 1'b1;
    bus.EN       = 1'b1;
    bus.BIST_END = 1'b0;
    bus.CUT_RESP = 8'hFF;
    tick();
    RESET        = 1'b0;
    bus.CUT_RESP = 8'h00;
    check("rst_pattern", bus.PATTERN, 8'h01);
    check("rst_sig", bus.SIGNATURE, 8'h00);
    check("rst_cnt", bus.PAT_CNT, 8'd0);
    check("rst_done", bus.DONE, 1'b0);
    check("rst_pass", bus.PASS, 1'b0);

    // First five patterns.
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("lfsr_seq%0d", i), bus.PATTERN, exp_seq[i]);
    end
    check("cnt5", bus.PAT_CNT, 8'd5);

    // Full period back to seed with no zero state, then saturation.
    seen_zero = 1'b0;
    for (int i = 5; i < 255; i++) begin
      tick();
      if (bus.PATTERN == 8'h00) seen_zero = 1'b1;
    end
    check("lfsr_no_zero", seen_zero, 1'b0);
    check("lfsr_period", bus.PATTERN, 8'h01);
    check("cnt255", bus.PAT_CNT, 8'd255);
    tick();
    check("cnt_sat", bus.PAT_CNT, 8'd255);
    check("lfsr_after_wrap", bus.PATTERN, 8'h02);
    check("sig_zero_resp", bus.SIGNATURE, 8'h00);

    // Abort back to IDLE.
    bus.RUNNING = 1'b0;
    bus.EN      = 1'b0;
    tick();
    check("abort1_pattern", bus.PATTERN, 8'h01);
    check("abort1_cnt", bus.PAT_CNT, 8'd0);

    // Single MISR fold of A5 from zero.
    bus.RUNNING  = 1'b1;
    bus.EN       = 1'b1;
    bus.CUT_RESP = 8'hA5;
    tick();
    check("misr_a5", bus.SIGNATURE, 8'hA5);
    bus.RUNNING  = 1'b0;
    bus.EN       = 1'b0;
    bus.CUT_RESP = 8'h00;
    tick();
    check("abort2_sig", bus.SIGNATURE, 8'h00);

    // 20 EN cycles with a round-boundary hold, then mid-session abort.
    mpat = 8'h01;
    bus.RUNNING = 1'b1;
    for (int i = 0; i < 21; i++) begin
      bus.EN = (i != 10);
      if (i != 10) mpat = nxt(mpat);
      tick();
      if (i == 10) begin
        check("hold_cnt", bus.PAT_CNT, 8'd10);
        check("hold_pattern", bus.PATTERN, mpat);
      end
    end
    check("cnt20", bus.PAT_CNT, 8'd20);
    check("pat20", bus.PATTERN, mpat);
    bus.RUNNING = 1'b0;
    bus.EN      = 1'b0;
    tick();
    check("abort3_pattern", bus.PATTERN, 8'h01);
    check("abort3_sig", bus.SIGNATURE, 8'h00);
    check("abort3_cnt", bus.PAT_CNT, 8'd0);

    // Clean 81-EN session, signature stays at golden 0.
    mpat = 8'h01;
    bus.RUNNING = 1'b1;
    bus.EN      = 1'b1;
    for (int i = 0; i < 81; i++) begin
      mpat = nxt(mpat);
      tick();
    end
    bus.EN       = 1'b0;
    bus.RUNNING  = 1'b0;
    bus.BIST_END = 1'b1;
    tick();
    check("clean_done_k", bus.DONE, 1'b0);
    tick();
    check("clean_done", bus.DONE, 1'b1);
    check("clean_pass", bus.PASS, 1'b1);
    check("clean_cnt", bus.PAT_CNT, 8'd81);
    check("clean_pattern", bus.PATTERN, mpat);
    bus.EN = 1'b1;
    tick();
    check("done_ignores_en_cnt", bus.PAT_CNT, 8'd81);
    check("done_ignores_en_pat", bus.PATTERN, mpat);
    check("done_hold", bus.DONE, 1'b1);
    bus.EN       = 1'b0;
    bus.BIST_END = 1'b0;
    tick();
    check("release_done", bus.DONE, 1'b0);
    check("release_pass", bus.PASS, 1'b0);
    check("release_pattern", bus.PATTERN, 8'h01);
    check("release_cnt", bus.PAT_CNT, 8'd0);

    // Faulty response session, then RESET while in DONE.
    inject_session(sig1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("rst_done_done", bus.DONE, 1'b0);
    check("rst_done_pass", bus.PASS, 1'b0);
    check("rst_done_pattern", bus.PATTERN, 8'h01);
    check("rst_done_sig", bus.SIGNATURE, 8'h00);
    bus.BIST_END = 1'b0;
    tick();

    // Second identical session reproduces the signature.
    inject_session(msig);
    check("repeat_sig", msig, sig1);
    bus.BIST_END = 1'b0;
    tick();
    check("final_done", bus.DONE, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bist_tpg_misr.md
# bist_tpg_misr

Pattern-generation and response-compaction stage of the BIST datapath. It sits directly downstream of the BIST controller and consumes that controller's RUNNING, OUT (pattern-enable) and BIST_END outputs. Each enabled cycle it drives an LFSR test pattern to the circuit under test (CUT) and folds the CUT response into a MISR. At end of test it compares the signature against a golden value and reports PASS/DONE.

## Interface
- W, 8: pattern/signature width (>= 4)
- TAPS, 8'hB8: feedback mask shared by LFSR and MISR (default x^8+x^6+x^5+x^4+1, primitive)
- SEED, 8'h01: LFSR load value; must be non-zero (zero locks the LFSR at 0)
- GOLDEN, 8'h00: expected final MISR signature
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  synchronous, active-high reset
- RUNNING  in  1  controller session-active flag
- EN  in  1  controller pattern-enable (controller OUT)
- BIST_END  in  1  controller end-of-test flag
- CUT_RESP  in  W  CUT response to current PATTERN
- PATTERN  out  W  current LFSR state, drives CUT inputs
- SIGNATURE  out  W  current MISR state
- PAT_CNT  out  8  EN cycles this session, saturates at 255
- DONE  out  1  comparison valid
- PASS  out  1  SIGNATURE == GOLDEN at end of test; meaningful only while DONE=1

## Operation
- Feedback: fb(x) = XOR-reduce(x & TAPS).
- LFSR step: PATTERN <= {PATTERN[W-2:0], fb(PATTERN)}.
- MISR step: SIGNATURE <= {SIGNATURE[W-2:0], fb(SIGNATURE)} ^ CUT_RESP.
- Both steps and PAT_CNT+1 (saturating) occur on an edge where EN=1 in IDLE or RUN. In CHECK and DONE, EN is ignored.
- States:
  - IDLE: PATTERN=SEED, SIGNATURE=0, PAT_CNT=0 held unless EN. Go to RUN when RUNNING=1.
  - RUN: step on EN; hold when EN=0. A round boundary (RUNNING=1, EN=0) is a plain hold. Go to CHECK when BIST_END=1. If RUNNING=0 and BIST_END=0 (controller reset mid-session), abort to IDLE with reload.
  - CHECK: single cycle; PASS <= (SIGNATURE == GOLDEN), DONE <= 1, go to DONE.
  - DONE: hold all outputs. When BIST_END=0, go to IDLE: reload PATTERN=SEED, SIGNATURE=0, PAT_CNT=0, and clear DONE and PASS.
- If EN=1 and BIST_END=1 arrive in the same cycle in RUN, the step is taken, then the block enters CHECK.
- Arithmetic is unsigned, width W. PAT_CNT saturates and does not wrap.

## Timing
- Reset (RESET=1 at edge, overrides all inputs): state=IDLE, PATTERN=SEED, SIGNATURE=0, PAT_CNT=0, DONE=0, PASS=0.
- All outputs are registered; there is no combinational input-to-output path.
- PATTERN is valid for the whole cycle. CUT_RESP for that pattern is sampled at the same edge that advances the LFSR (one-cycle CUT path).
- BIST_END high at edge k puts the block in CHECK at k. DONE and PASS are valid after edge k+1.
- The new session resets on the edge where BIST_END=0 is sampled in DONE. The following session's first EN is accepted from IDLE.

## Test plan
- Reset, then EN pulsed 5 cycles with RUNNING=1 -> PATTERN sequence 01,02,04,08,11,23 and PAT_CNT=5.
- EN held 255 cycles -> PATTERN returns to 8'h01, no intermediate 00, PAT_CNT=255. A 256th EN cycle leaves PAT_CNT at 255.
- From SIGNATURE=0, one EN cycle with CUT_RESP=8'hA5 -> SIGNATURE=8'hA5. Full 81-EN session with CUT_RESP=0 and GOLDEN=0, then BIST_END -> DONE=1 and PASS=1 two edges after BIST_END.
- Same session with CUT_RESP=8'h01 injected on pattern 40 only -> SIGNATURE!=0 and PASS=0 with DONE=1. Compare SIGNATURE against a bench reference model.
- Mid-session abort (RUNNING and BIST_END both 0 after 20 EN cycles) -> IDLE next edge, PATTERN=01, SIGNATURE=0, PAT_CNT=0.
- RESET=1 asserted in DONE, and separately BIST_END dropped in DONE -> both cases give DONE=0, PASS=0, PATTERN=SEED after one edge. A second session then reproduces an identical signature.
